// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Time-shares one single-port, byte-wide RAM between an instruction-fetch
// port (read only) and a data port (load/store). Each transaction moves one
// 32-bit little-endian word as four byte accesses at base..base+3, where
// byte k sits at base+k and maps to word bits [8k+7:8k].
//
// Timing, counted from the IDLE cycle in which the request is granted (cycle 0):
//   store: bytes written in cycles 1..4, d_ack in cycle 5
//   load : addresses in cycles 1..4, data captured in cycles 2..5, ack in cycle 6
// An IDLE cycle that carries an ack never grants. This gives a one-cycle
// turnaround, so a request held through its own ack is granted again in the
// next cycle.
//
// Configuration macro:
//   ARB_RR_EN  defined   : ties go to the port that was not granted last
//              undefined : fixed priority, the data port always wins a tie
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   i_req, i_addr             fetch request, byte address (bits [1:0] ignored)
//   i_ack, i_rdata            fetch done pulse, fetched word
//   d_req, d_we, d_addr,
//   d_wdata                   data request, 1=store, byte address, store word
//   d_ack, d_rdata            data done pulse, load word
//   mem_addr, mem_we,
//   mem_wdata, mem_rdata      byte RAM port (read data one cycle after address)
//   busy                      high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  // instruction-fetch port
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [31:0]       i_rdata,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  // byte RAM
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  // status
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t              r_state;
  logic [1:0]          r_cnt;
  logic [ADDR_W-1:2]   r_base_hi;   // word base; byte lane comes from r_cnt
  logic                r_we;
  logic [31:0]         r_wdata;
  logic                r_port_d;    // 1 = data port owns the transfer
  logic [23:0]         r_rbuf;      // load bytes 0..2; byte 3 lands directly
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_mem_we;
  logic [7:0]          r_mem_wdata;

  logic                w_grant;
  logic                w_pick_d;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic                w_sel_we;
  logic [1:0]          w_next_cnt;
  logic                w_unused_addr_lsbs;

  // Byte-lane bits of both addresses are ignored: transfers are word aligned.
  assign w_unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0]};

  // Acks are registered, so an ack-high cycle is always an IDLE cycle.
  assign w_grant = (r_state == IDLE) && (i_req || d_req) && !i_ack && !d_ack;

`ifdef ARB_RR_EN
  logic r_prefer_d;  // port that wins the next tie
  assign w_pick_d = d_req && (!i_req || r_prefer_d);
`else
  assign w_pick_d = d_req;
`endif

  assign w_sel_addr = w_pick_d ? d_addr : i_addr;
  // Fetches are always reads, whatever d_we happens to be.
  assign w_sel_we   = w_pick_d && d_we;
  assign w_next_cnt = r_cnt + 2'd1;

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  // NOTE: the strobe is masked by rst so that the byte in flight when a
  // synchronous reset is sampled is not written at that same edge.
  assign mem_we    = r_mem_we && !rst;
  assign busy      = (r_state != IDLE);

  // NOTE: all state updates use non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= 2'd0;
      r_base_hi   <= '0;
      r_we        <= 1'b0;
      r_wdata     <= 32'd0;
      r_port_d    <= 1'b1;
      r_rbuf      <= 24'd0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= 8'd0;
      i_ack       <= 1'b0;
      d_ack       <= 1'b0;
      i_rdata     <= 32'd0;
      d_rdata     <= 32'd0;
`ifdef ARB_RR_EN
      r_prefer_d  <= 1'b1;
`endif
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_grant) begin
            // Everything the transfer needs is captured here; later input
            // changes have no effect until the next grant.
            r_base_hi   <= w_sel_addr[ADDR_W-1:2];
            r_we        <= w_sel_we;
            r_wdata     <= d_wdata;
            r_port_d    <= w_pick_d;
            r_cnt       <= 2'd0;
            r_mem_addr  <= {w_sel_addr[ADDR_W-1:2], 2'b00};
            r_mem_we    <= w_sel_we;
            r_mem_wdata <= d_wdata[7:0];
            r_state     <= XFER;
`ifdef ARB_RR_EN
            r_prefer_d  <= !w_pick_d;
`endif
          end
        end

        XFER: begin
          // mem_rdata now holds the byte addressed in the previous cycle.
          case (r_cnt)
            2'd1:    r_rbuf[7:0]   <= mem_rdata;
            2'd2:    r_rbuf[15:8]  <= mem_rdata;
            2'd3:    r_rbuf[23:16] <= mem_rdata;
            default: ;
          endcase

          if (r_cnt == 2'd3) begin
            // mem_addr keeps its last value outside XFER.
            r_mem_we <= 1'b0;
            r_cnt    <= 2'd0;
            if (r_we) begin
              r_state <= IDLE;
              if (r_port_d) d_ack <= 1'b1;
              else          i_ack <= 1'b1;
            end else begin
              r_state <= FIN;
            end
          end else begin
            r_cnt       <= w_next_cnt;
            // The lane counter forms the low bits, so base 0xFC stops at 0xFF.
            r_mem_addr  <= {r_base_hi, w_next_cnt};
            r_mem_wdata <= r_wdata[{w_next_cnt, 3'b000} +: 8];
          end
        end

        FIN: begin
          r_state <= IDLE;
          if (r_port_d) begin
            d_rdata <= {mem_rdata, r_rbuf};
            d_ack   <= 1'b1;
          end else begin
            i_rdata <= {mem_rdata, r_rbuf};
            i_ack   <= 1'b1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 8, byte-address width of the shared memory (2^8 x 8bit).
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 i_req  in  1  instruction-fetch read request (IF stage).
REQ-005 i_addr  in  ADDR_W  instruction byte address; bits [1:0] ignored.
REQ-006 i_ack  out  1  one-cycle pulse, fetch complete.
REQ-007 i_rdata  out  32  fetched word, valid from i_ack until next i_ack.
REQ-008 d_req  in  1  data request (MEM stage).
REQ-009 d_we  in  1  1 = store, 0 = load.
REQ-010 d_addr  in  ADDR_W  data byte address; bits [1:0] ignored.
REQ-011 d_wdata  in  32  store word.
REQ-012 d_ack  out  1  one-cycle pulse, data access complete.
REQ-013 d_rdata  out  32  load word, valid from d_ack until next d_ack.
REQ-014 mem_addr  out  ADDR_W  byte address to single-port byte RAM.
REQ-015 mem_we  out  1  byte write strobe.
REQ-016 mem_wdata  out  8  byte write data.
REQ-017 mem_rdata  in  8  RAM read data, valid the cycle after mem_addr is presented.
REQ-018 busy  out  1  high whenever state != IDLE.

Function
REQ-019 The block SHALL time-share one byte-wide RAM between the IF and MEM ports, moving 32-bit little-endian words (byte k at base+k, word bits [8k+7:8k]).
REQ-020 FSM states SHALL be IDLE, XFER, FIN; XFER carries a 2-bit byte counter cnt.
REQ-021 In IDLE with any req high and both acks low, the block SHALL latch the winner's base address ({addr[ADDR_W-1:2],2'b00}), we, wdata and port id, and go to XFER with cnt=0.
REQ-022 In IDLE during a cycle where i_ack or d_ack is high, requests SHALL be ignored (one-cycle turnaround).
REQ-023 In XFER, mem_addr SHALL equal base+cnt; mem_we SHALL equal latched we; mem_wdata SHALL be latched wdata byte cnt; cnt increments each cycle.
REQ-024 Load: byte k SHALL be captured from mem_rdata one cycle after its address; after cnt=3 go to FIN, capture byte 3 in FIN, then IDLE with the port's ack high next cycle.
REQ-025 Store: after cnt=3 go directly to IDLE with the port's ack high next cycle; FIN is not entered.
REQ-026 Latency from request sampled in IDLE (cycle 0): load ack in cycle 6, store ack in cycle 5.
REQ-027 Outside XFER, mem_we SHALL be 0 and mem_addr SHALL hold its last value.
REQ-028 Fetch requests SHALL always be treated as reads regardless of d_we.
REQ-029 Fixed priority: when both req are high in a granting IDLE cycle, the data port SHALL win; IF may starve while d_req stays high.
REQ-030 Inputs SHALL be sampled only at grant; changes after grant do not affect the transfer.
REQ-031 A request still high in its own ack cycle SHALL be regranted in the following cycle if it wins arbitration.
REQ-032 Base address 0xFC SHALL access 0xFC..0xFF; no address wrap occurs for aligned words.

Reset
REQ-033 On rst: state IDLE, cnt 0, i_ack 0, d_ack 0, mem_we 0, mem_addr 0, mem_wdata 0, i_rdata 0, d_rdata 0, busy 0, round-robin pointer = data.
REQ-034 rst during XFER/FIN SHALL abort with no ack; store bytes already written remain in RAM.

Configuration
REQ-035 Macro ARB_RR_EN: when defined, ties SHALL go to the port not granted last (pointer updated at each grant); when undefined, fixed data priority per REQ-029 and no pointer logic is built.

Verification
REQ-036 RAM preset 0x10..0x13 = 44,33,22,11; i_req, i_addr=0x12 -> i_ack in cycle 6, i_rdata=0x11223344.
REQ-037 d_req, d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF -> writes EF,BE,AD,DE to 0x20..0x23, d_ack in cycle 5; load of 0x20 returns 0xDEADBEEF.
REQ-038 i_req and d_req both high, continuously -> without ARB_RR_EN only d_ack pulses; with ARB_RR_EN grants alternate D,I,D,I.
REQ-039 rst asserted in XFER cnt=2 of store to 0x40 -> no ack, 0x40/0x41 written, 0x42/0x43 unchanged, all outputs per REQ-033 next cycle.
REQ-040 d_addr=0xFC load, RAM 0xFC..0xFF = 01,02,03,04 -> d_rdata=0x04030201, mem_addr never exceeds 0xFF.
